// File: rtl/time_of_day_counter.sv
`default_nettype none
// ============================================================================
//  Module   : time_of_day_counter
//  Purpose  : Packed-BCD HH:MM:SS wall clock driven by a 1 Hz tick, with a
//             SET mode for hour/minute adjustment. Define CLOCK_12H_EN for
//             the 12 h (AM/PM) build; the default build is 24 h.
//  Revision : 1.0  initial release
// ============================================================================
module time_of_day_counter #(
    parameter logic [7:0] INIT_HR  = 8'h00,
    parameter logic [7:0] INIT_MIN = 8'h00
) (
    input  logic       i_clk,
    input  logic       i_reset_n,
    input  logic       i_tick_1hz,
    input  logic       i_set_mode,
    input  logic       i_inc_hr,
    input  logic       i_inc_min,
    output logic [7:0] o_hours,
    output logic [7:0] o_minutes,
    output logic [7:0] o_seconds,
    output logic       o_pm,
    output logic       o_setting,
    output logic       o_min_tick,
    output logic       o_day_tick
);

    typedef enum logic {
        ST_RUN = 1'b0,
        ST_SET = 1'b1
    } state_t;

    state_t     r_state;
    logic [7:0] r_hours;
    logic [7:0] r_minutes;
    logic [7:0] r_seconds;
    logic       r_min_tick;
    logic       r_day_tick;

    logic [8:0] w_sec_inc;
    logic [8:0] w_min_inc;
    logic [8:0] w_hr_inc;
    logic       w_day_wrap;

    // Returns {carry, next} for a 00..59 BCD field.
    function automatic logic [8:0] inc_mod60(input logic [7:0] v);
        if (v[3:0] == 4'd9) begin
            if (v[7:4] == 4'd5)
                return {1'b1, 8'h00};
            else
                return {1'b0, v[7:4] + 4'd1, 4'd0};
        end
        return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

`ifdef CLOCK_12H_EN
    // Returns {pm_toggle, next}; the AM/PM flip happens on 11 -> 12.
    function automatic logic [8:0] inc_hr12(input logic [7:0] v);
        if (v == 8'h12)
            return {1'b0, 8'h01};
        if (v == 8'h11)
            return {1'b1, 8'h12};
        if (v[3:0] == 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    logic r_pm;

    assign w_hr_inc   = inc_hr12(r_hours);
    // 11 PM -> 12 AM is the only pm toggle that lands on midnight.
    assign w_day_wrap = w_hr_inc[8] & r_pm;
    assign o_pm       = r_pm;
`else
    // Returns {day_wrap, next} for a 00..23 BCD field.
    function automatic logic [8:0] inc_hr24(input logic [7:0] v);
        if (v == 8'h23)
            return {1'b1, 8'h00};
        if (v[3:0] == 4'd9)
            return {1'b0, v[7:4] + 4'd1, 4'd0};
        return {1'b0, v[7:4], v[3:0] + 4'd1};
    endfunction

    assign w_hr_inc   = inc_hr24(r_hours);
    assign w_day_wrap = w_hr_inc[8];
    assign o_pm       = 1'b0;
`endif

    assign w_sec_inc = inc_mod60(r_seconds);
    assign w_min_inc = inc_mod60(r_minutes);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state    <= ST_RUN;
            r_hours    <= INIT_HR;
            r_minutes  <= INIT_MIN;
            r_seconds  <= 8'h00;
            r_min_tick <= 1'b0;
            r_day_tick <= 1'b0;
`ifdef CLOCK_12H_EN
            r_pm       <= 1'b0;
`endif
        end else begin
            r_min_tick <= 1'b0;
            r_day_tick <= 1'b0;
            if (r_state == ST_RUN) begin
                if (i_tick_1hz) begin
                    r_seconds <= w_sec_inc[7:0];
                    if (w_sec_inc[8]) begin
                        r_min_tick <= 1'b1;
                        r_minutes  <= w_min_inc[7:0];
                        if (w_min_inc[8]) begin
                            r_hours    <= w_hr_inc[7:0];
                            r_day_tick <= w_day_wrap;
`ifdef CLOCK_12H_EN
                            if (w_hr_inc[8])
                                r_pm <= ~r_pm;
`endif
                        end
                    end
                end
                // A coincident tick still carries, but SET always shows :00.
                if (i_set_mode) begin
                    r_state   <= ST_SET;
                    r_seconds <= 8'h00;
                end
            end else begin
                if (i_inc_min)
                    r_minutes <= w_min_inc[7:0];
                if (i_inc_hr) begin
                    r_hours <= w_hr_inc[7:0];
`ifdef CLOCK_12H_EN
                    if (w_hr_inc[8])
                        r_pm <= ~r_pm;
`endif
                end
                if (!i_set_mode)
                    r_state <= ST_RUN;
            end
        end
    end

    assign o_hours    = r_hours;
    assign o_minutes  = r_minutes;
    assign o_seconds  = r_seconds;
    assign o_setting  = (r_state == ST_SET);
    assign o_min_tick = r_min_tick;
    assign o_day_tick = r_day_tick;

endmodule
`default_nettype wire

// File: tb/tb_time_of_day_counter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_time_of_day_counter
//  Purpose  : Scoreboard bench for time_of_day_counter (24 h or CLOCK_12H_EN).
//  Revision : 1.0  initial release
// ============================================================================
module tb_time_of_day_counter;

    localparam logic [7:0] INIT_HR  = 8'h09;
    localparam logic [7:0] INIT_MIN = 8'h30;
    localparam int         INIT_H24 = 9;
    localparam int         INIT_M   = 30;

    logic       i_clk      = 1'b0;
    logic       i_reset_n  = 1'b0;
    logic       i_tick_1hz = 1'b0;
    logic       i_set_mode = 1'b0;
    logic       i_inc_hr   = 1'b0;
    logic       i_inc_min  = 1'b0;
    logic [7:0] o_hours;
    logic [7:0] o_minutes;
    logic [7:0] o_seconds;
    logic       o_pm;
    logic       o_setting;
    logic       o_min_tick;
    logic       o_day_tick;

    time_of_day_counter #(
        .INIT_HR  (INIT_HR),
        .INIT_MIN (INIT_MIN)
    ) dut (
        .i_clk      (i_clk),
        .i_reset_n  (i_reset_n),
        .i_tick_1hz (i_tick_1hz),
        .i_set_mode (i_set_mode),
        .i_inc_hr   (i_inc_hr),
        .i_inc_min  (i_inc_min),
        .o_hours    (o_hours),
        .o_minutes  (o_minutes),
        .o_seconds  (o_seconds),
        .o_pm       (o_pm),
        .o_setting  (o_setting),
        .o_min_tick (o_min_tick),
        .o_day_tick (o_day_tick)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [7:0] hr;
        logic [7:0] mn;
        logic [7:0] sc;
        logic       pm;
        logic       st;
        logic       mt;
        logic       dt;
    } exp_t;

    exp_t sb[$];
    exp_t r_pop;
    int   n_cmp = 0;
    int   n_err = 0;

    // Reference model keeps time as 24 h integers; the display form is derived.
    int m_h;
    int m_m;
    int m_s;
    bit m_set;

    function automatic logic [7:0] bcd(input int v);
        logic [3:0] t;
        logic [3:0] u;
        t = 4'(v / 10);
        u = 4'(v % 10);
        return {t, u};
    endfunction

    function automatic exp_t expect_now(input bit mt, input bit dt);
        exp_t e;
`ifdef CLOCK_12H_EN
        e.hr = bcd((m_h % 12 == 0) ? 12 : (m_h % 12));
        e.pm = (m_h >= 12);
`else
        e.hr = bcd(m_h);
        e.pm = 1'b0;
`endif
        e.mn = bcd(m_m);
        e.sc = bcd(m_s);
        e.st = m_set;
        e.mt = mt;
        e.dt = dt;
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all(input exp_t e);
        check("hours",    32'(o_hours),    32'(e.hr));
        check("minutes",  32'(o_minutes),  32'(e.mn));
        check("seconds",  32'(o_seconds),  32'(e.sc));
        check("pm",       32'(o_pm),       32'(e.pm));
        check("setting",  32'(o_setting),  32'(e.st));
        check("min_tick", 32'(o_min_tick), 32'(e.mt));
        check("day_tick", 32'(o_day_tick), 32'(e.dt));
    endtask

    task automatic model_reset();
        m_h   = INIT_H24;
        m_m   = INIT_M;
        m_s   = 0;
        m_set = 1'b0;
    endtask

    // Drive one cycle of inputs and push what the DUT must show after the edge.
    task automatic cycle(input bit tk, input bit md, input bit ih, input bit im);
        bit mt;
        bit dt;
        @(negedge i_clk);
        i_tick_1hz = tk;
        i_set_mode = md;
        i_inc_hr   = ih;
        i_inc_min  = im;
        mt = 1'b0;
        dt = 1'b0;
        if (!m_set) begin
            if (tk) begin
                m_s++;
                if (m_s == 60) begin
                    m_s = 0;
                    mt  = 1'b1;
                    m_m++;
                    if (m_m == 60) begin
                        m_m = 0;
                        m_h = (m_h + 1) % 24;
                        dt  = (m_h == 0);
                    end
                end
            end
            if (md)
                m_s = 0;
        end else begin
            if (im) m_m = (m_m + 1) % 60;
            if (ih) m_h = (m_h + 1) % 24;
        end
        m_set = md;
        sb.push_back(expect_now(mt, dt));
        @(posedge i_clk);
    endtask

    task automatic goto_time(input int h, input int m, input int s);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        while (m_h != h) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        while (m_m != m) cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        while (m_s != s) cycle(1'b1, 1'b0, 1'b0, 1'b0);
    endtask

    always @(posedge i_clk) begin
        #1;
        if (sb.size() != 0) begin
            r_pop = sb.pop_front();
            check_all(r_pop);
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge i_clk);
        #1;
        check_all(expect_now(1'b0, 1'b0));
        @(negedge i_clk);
        i_reset_n = 1'b1;

        // First ticks after reset, spaced out
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Midnight rollover
        goto_time(23, 59, 58);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // SET mode ignores ticks, applies increments
        goto_time(10, 15, 42);
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (5) cycle(1'b1, 1'b1, 1'b0, 1'b0);
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Minute wrap without hour carry, then simultaneous increments
        cycle(1'b0, 1'b1, 1'b0, 1'b0);
        while (m_h != 10) cycle(1'b0, 1'b1, 1'b1, 1'b0);
        while (m_m != 59) cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 1'b1, 1'b1);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Tick on mode rise counts, tick on mode fall is dropped
        while (m_s != 59) cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in mid-cycle while in SET
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 1'b1, 1'b1, 1'b0);
        @(negedge i_clk);
        #2;
        i_reset_n = 1'b0;
        #1;
        model_reset();
        check_all(expect_now(1'b0, 1'b0));
        @(negedge i_clk);
        i_set_mode = 1'b0;
        i_inc_hr   = 1'b0;
        i_reset_n  = 1'b1;
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        // Hour boundaries: noon, 12 -> 1, and midnight again
        goto_time(11, 59, 59);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        goto_time(12, 59, 59);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        goto_time(23, 59, 59);
        cycle(1'b1, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 1'b0, 1'b0);

        @(negedge i_clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
